// File: rtl/spi_txn_scheduler_pkg.sv
// Shared types and constants for the SPI transaction scheduler.
// State encoding, field widths and parameter defaults.
package rcb_spi_sched_pkg;

    localparam int COM_W  = 8;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam int              TIMEOUT_DEF  = 10000;
    localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_COMPLETE
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_txn_scheduler_if.sv
// Requester-side and engine-side signal bundle of the scheduler.
// slave = scheduler view, master = the surrounding logic's view.
interface spi_txn_scheduler_if
    import rcb_spi_sched_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]        req;
    logic [NREQ*COM_W-1:0]  req_com;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        ack;
    logic [DATA_W-1:0]      rdata;
    logic                   err;
    logic                   busy;
    logic                   spi_run;
    logic [COM_W-1:0]       spi_com;
    logic [ADDR_W-1:0]      spi_addr;
    logic [DATA_W-1:0]      mosi_data;
    logic [DATA_W-1:0]      miso_data;
    logic                   spi_done;

    modport slave (
        input  req, req_com, req_addr, req_wdata,
        input  miso_data, spi_done,
        output gnt, ack, rdata, err, busy,
        output spi_run, spi_com, spi_addr, mosi_data
    );

    modport master (
        output req, req_com, req_addr, req_wdata,
        output miso_data, spi_done,
        input  gnt, ack, rdata, err, busy,
        input  spi_run, spi_com, spi_addr, mosi_data
    );

endinterface

// File: rtl/spi_txn_scheduler_arb.sv
// Combinational round-robin arbiter: first set request at or
// above i_ptr, wrapping, wins.
module rr_arbiter
    import rcb_spi_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        i_req,
    input  logic [idx_w(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]        o_grant,
    output logic [idx_w(NREQ)-1:0] o_idx
);

    localparam int IW = idx_w(NREQ);

    always_comb begin
        int  k;
        logic w_found;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(i_ptr) + i) % NREQ;
            if (!w_found && i_req[k]) begin
                w_found    = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = IW'(k);
            end
        end
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one SPI master engine between NREQ requesters, round-robin,
// with a watchdog that aborts transfers the engine never completes.
module spi_txn_scheduler
    import rcb_spi_sched_pkg::*;
#(
    parameter int                NREQ        = 4,
    parameter int                TIMEOUT_CYC = TIMEOUT_DEF,
    parameter logic [DATA_W-1:0] ERR_DATA    = ERR_DATA_DEF
) (
    input logic clk_100m,
    input logic rst_n,
    spi_txn_scheduler_if.slave bus
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = idx_w(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    state_t              r_state;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_win;
    logic [CW-1:0]       r_cnt;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_busy;
    logic                r_run;
    logic [COM_W-1:0]    r_com;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic [NREQ-1:0]     w_grant;
    logic [IW-1:0]       w_idx;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_run   <= 1'b0;
            r_com   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_run <= 1'b0;
            r_ack <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        r_win   <= w_idx;
                        r_gnt   <= w_grant;
                        r_com   <= bus.req_com[int'(w_idx)*COM_W +: COM_W];
                        r_addr  <= bus.req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
                        r_wdata <= bus.req_wdata[int'(w_idx)*DATA_W +: DATA_W];
                        r_run   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the timeout cycle still wins.
                    if (bus.spi_done) begin
                        r_rdata <= bus.miso_data;
                        r_err   <= 1'b0;
                        r_ack   <= r_gnt;
                        r_state <= ST_COMPLETE;
                    end else if (r_cnt == LAST) begin
                        r_rdata <= ERR_DATA;
                        r_err   <= 1'b1;
                        r_ack   <= r_gnt;
                        r_state <= ST_COMPLETE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_COMPLETE: begin
                    r_ptr   <= (int'(r_win) == NREQ - 1) ? '0 : r_win + IW'(1);
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.ack       = r_ack;
    assign bus.rdata     = r_rdata;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;
    assign bus.spi_run   = r_run;
    assign bus.spi_com   = r_com;
    assign bus.spi_addr  = r_addr;
    assign bus.mosi_data = r_wdata;

endmodule
